// File: rtl/traffic_gen_checker_if.sv
// ---------------------------------------------------------------------------
// traffic_gen_checker_if
// Bundles the FIFO-side signals between the traffic generator/checker and the
// NCH-input / NCH-output FIFO switch it exercises.
//   push           : push strobes into the input FIFOs
//   data_in_flat   : input FIFO write data, channel i at [i*DATA_W +: DATA_W]
//   almost_full_in : almost-full flags of the input FIFOs
//   pop            : pop strobes to the output FIFOs
//   data_out_flat  : output FIFO read data, valid the cycle after pop
//   out_empty      : empty flags of the output FIFOs
// master = generator/checker side, slave = switch/FIFO side.
// ---------------------------------------------------------------------------
interface traffic_gen_checker_if #(
    parameter int NCH    = 4,
    parameter int DATA_W = 10
);
    logic [NCH-1:0]        push;
    logic [NCH*DATA_W-1:0] data_in_flat;
    logic [NCH-1:0]        almost_full_in;
    logic [NCH-1:0]        pop;
    logic [NCH*DATA_W-1:0] data_out_flat;
    logic [NCH-1:0]        out_empty;

    modport master (
        output push, data_in_flat, pop,
        input  almost_full_in, out_empty, data_out_flat
    );

    modport slave (
        input  push, data_in_flat, pop,
        output almost_full_in, out_empty, data_out_flat
    );
endinterface

// File: rtl/traffic_gen_checker.sv
// ---------------------------------------------------------------------------
// traffic_gen_checker
// Stimulus generator and checker for an NCH x NCH FIFO switch. After a start
// pulse it pushes num_words words into every input FIFO, pops the output
// FIFOs, and checks the destination and per-(src,dest) sequence of every
// received word. Per-output received-word counters are readable via idx/req.
// Ports:
//   clk, reset      : clock (rising edge), asynchronous active-low reset
//   start           : one-cycle start pulse (honoured in IDLE or DONE)
//   mode            : 0 = straight (i -> i), 1 = all-to-all (word k -> k mod NCH)
//   num_words       : words per input channel, latched on start
//   hold_pop        : suppress all pops
//   bus             : FIFO-side interface (master modport)
//   idx, req        : counter read select / request
//   valid_cnt       : read data valid (one cycle after req)
//   cnt_out         : received-word count of output idx
//   busy, done      : SEND/DRAIN and DONE state indicators
//   error           : sticky error (mismatch or drain timeout)
//   err_count       : saturating mismatch count
// Word format: {dest[DEST_W], src[DEST_W], seq[DATA_W-2*DEST_W]}.
// ---------------------------------------------------------------------------
module traffic_gen_checker #(
    parameter int NCH     = 4,
    parameter int DATA_W  = 10,
    parameter int DEST_W  = 2,
    parameter int CNT_W   = 5,
    parameter int TIMEOUT = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [CNT_W-1:0]      num_words,
    input  logic                  hold_pop,
    traffic_gen_checker_if.master bus,
    input  logic [DEST_W-1:0]     idx,
    input  logic                  req,
    output logic                  valid_cnt,
    output logic [CNT_W-1:0]      cnt_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CNT_W-1:0]      err_count
);

    localparam int SEQ_W  = DATA_W - 2 * DEST_W;
    localparam int TOT_W  = CNT_W + DEST_W + 1;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DRAIN, ST_DONE} state_t;

    state_t              state_reg;
    logic                mode_reg;
    logic [CNT_W-1:0]    num_words_reg;
    logic [CNT_W-1:0]    sent_reg    [NCH];
    logic [DATA_W-1:0]   data_in_reg [NCH];
    logic [CNT_W-1:0]    rx_reg      [NCH];
    logic [SEQ_W-1:0]    exp_reg     [NCH][NCH];   // [src][dest] next expected seq
    logic [NCH-1:0]      push_reg;
    logic [NCH-1:0]      pop_reg;
    logic [NCH-1:0]      chk_reg;                  // pop issued last cycle -> data valid now
    logic [TOT_W-1:0]    total_reg;
    logic [IDLE_W-1:0]   idle_reg;
    logic                error_reg;
    logic [CNT_W-1:0]    err_count_reg;
    logic                valid_cnt_reg;
    logic [CNT_W-1:0]    cnt_out_reg;

    logic [NCH-1:0]      push_ok;
    logic [NCH-1:0]      sent_all;
    logic [NCH-1:0]      mism;
    logic [DATA_W-1:0]   word_next [NCH];
    logic [DATA_W-1:0]   word_rx   [NCH];
    logic [DEST_W-1:0]   rx_dest   [NCH];
    logic [DEST_W-1:0]   rx_src    [NCH];
    logic [SEQ_W-1:0]    rx_seq    [NCH];

    logic [DEST_W:0]     n_mism;
    logic [DEST_W:0]     n_rx;
    logic [CNT_W:0]      err_sum;
    logic [CNT_W-1:0]    err_count_next;
    logic [TOT_W-1:0]    target;
    logic                pop_en;

    // Per-channel word generation, flat-bus packing and received-word decode
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [DEST_W-1:0] tx_dest;
            logic [SEQ_W-1:0]  tx_seq;

            assign push_ok[gi]  = (sent_reg[gi] < num_words_reg) && !bus.almost_full_in[gi];
            assign sent_all[gi] = (sent_reg[gi] == num_words_reg);

            // All-to-all: word k goes to k mod NCH and is the (k / NCH)-th word
            // of that (src,dest) pair; straight: dest is the channel itself.
            assign tx_dest = mode_reg ? sent_reg[gi][DEST_W-1:0] : DEST_W'(gi);
            assign tx_seq  = mode_reg ? SEQ_W'(sent_reg[gi] >> DEST_W) : SEQ_W'(sent_reg[gi]);
            assign word_next[gi] = {tx_dest, DEST_W'(gi), tx_seq};

            assign bus.data_in_flat[gi*DATA_W +: DATA_W] = data_in_reg[gi];

            assign word_rx[gi] = bus.data_out_flat[gi*DATA_W +: DATA_W];
            assign rx_dest[gi] = word_rx[gi][DATA_W-1 -: DEST_W];
            assign rx_src[gi]  = word_rx[gi][DATA_W-DEST_W-1 -: DEST_W];
            assign rx_seq[gi]  = word_rx[gi][SEQ_W-1:0];

            assign mism[gi] = chk_reg[gi] &&
                              ((rx_dest[gi] != DEST_W'(gi)) ||
                               (rx_seq[gi] != exp_reg[rx_src[gi]][gi]));
        end
    endgenerate

    always_comb begin
        n_mism = '0;
        n_rx   = '0;
        for (int j = 0; j < NCH; j++) begin
            n_mism = n_mism + (DEST_W+1)'(mism[j]);
            n_rx   = n_rx   + (DEST_W+1)'(chk_reg[j]);
        end
        err_sum        = {1'b0, err_count_reg} + (CNT_W+1)'(n_mism);
        err_count_next = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
        target         = TOT_W'(num_words_reg) << DEST_W;
        pop_en         = (state_reg == ST_SEND) || (state_reg == ST_DRAIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            mode_reg      <= 1'b0;
            num_words_reg <= '0;
            push_reg      <= '0;
            pop_reg       <= '0;
            chk_reg       <= '0;
            total_reg     <= '0;
            idle_reg      <= '0;
            error_reg     <= 1'b0;
            err_count_reg <= '0;
            valid_cnt_reg <= 1'b0;
            cnt_out_reg   <= '0;
            for (int i = 0; i < NCH; i++) begin
                sent_reg[i]    <= '0;
                data_in_reg[i] <= '0;
                rx_reg[i]      <= '0;
                for (int j = 0; j < NCH; j++) begin
                    exp_reg[i][j] <= '0;
                end
            end
        end else begin
            push_reg <= '0;
            chk_reg  <= pop_reg;

            // At most one pop every other cycle per output, so out_empty is
            // always re-sampled after the previous pop has taken effect.
            for (int j = 0; j < NCH; j++) begin
                pop_reg[j] <= pop_en && !bus.out_empty[j] && !hold_pop && !pop_reg[j];
            end

            // The expected sequence advances even on a mismatch so one bad word
            // does not cascade into errors on every following word.
            for (int j = 0; j < NCH; j++) begin
                if (chk_reg[j]) begin
                    exp_reg[rx_src[j]][j] <= exp_reg[rx_src[j]][j] + SEQ_W'(1);
                    rx_reg[j]             <= rx_reg[j] + CNT_W'(1);
                end
            end
            total_reg     <= total_reg + TOT_W'(n_rx);
            err_count_reg <= err_count_next;
            if (|mism) begin
                error_reg <= 1'b1;
            end

            // Reads see the counter before this cycle's increment
            valid_cnt_reg <= req;
            if (req) begin
                cnt_out_reg <= rx_reg[idx];
            end

            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_reg      <= mode;
                        num_words_reg <= num_words;
                        total_reg     <= '0;
                        idle_reg      <= '0;
                        error_reg     <= 1'b0;
                        err_count_reg <= '0;
                        for (int i = 0; i < NCH; i++) begin
                            sent_reg[i] <= '0;
                            rx_reg[i]   <= '0;
                            for (int j = 0; j < NCH; j++) begin
                                exp_reg[i][j] <= '0;
                            end
                        end
                        state_reg <= (num_words == '0) ? ST_DONE : ST_SEND;
                    end
                end
                ST_SEND: begin
                    idle_reg <= '0;
                    for (int i = 0; i < NCH; i++) begin
                        if (push_ok[i]) begin
                            push_reg[i]    <= 1'b1;
                            data_in_reg[i] <= word_next[i];
                            sent_reg[i]    <= sent_reg[i] + CNT_W'(1);
                        end
                    end
                    if (&sent_all) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (total_reg == target) begin
                        state_reg <= ST_DONE;
                    end else if (!hold_pop && (pop_reg == '0)) begin
                        // Only cycles that could have popped count towards the timeout
                        idle_reg <= idle_reg + IDLE_W'(1);
                        if (idle_reg == IDLE_W'(TIMEOUT - 1)) begin
                            state_reg <= ST_DONE;
                            error_reg <= 1'b1;
                        end
                    end else begin
                        idle_reg <= '0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.push  = push_reg;
    assign bus.pop   = pop_reg;
    assign valid_cnt = valid_cnt_reg;
    assign cnt_out   = cnt_out_reg;
    assign busy      = (state_reg == ST_SEND) || (state_reg == ST_DRAIN);
    assign done      = (state_reg == ST_DONE);
    assign error     = error_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_traffic_gen_checker.sv
// ---------------------------------------------------------------------------
// tb_traffic_gen_checker
// Environment: behavioural input FIFOs (with almost-full threshold), a switch
// that routes each input head to the output FIFO named by its dest field, and
// output FIFOs with registered read data. Expected traffic is built from the
// word-format rules with plain arithmetic and kept in per-(src,dest) queues.
// All sampling, modelling and checking happens on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_traffic_gen_checker;
    localparam int NCH = 4, DATA_W = 10, DEST_W = 2, CNT_W = 5, TIMEOUT = 32;
    localparam int SEQ_W = DATA_W - 2 * DEST_W;
    localparam int IN_DEPTH = 4, OUT_DEPTH = 8, OUT_AF = 5, FAULT_J = 1;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, mode = 1'b0, hold_pop = 1'b0, req = 1'b0;
    logic [CNT_W-1:0]  num_words = '0;
    logic [DEST_W-1:0] idx = '0;
    logic              valid_cnt, busy, done, error;
    logic [CNT_W-1:0]  cnt_out, err_count;

    traffic_gen_checker_if #(.NCH(NCH), .DATA_W(DATA_W)) bus ();

    traffic_gen_checker #(
        .NCH(NCH), .DATA_W(DATA_W), .DEST_W(DEST_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .num_words(num_words),
        .hold_pop(hold_pop), .bus(bus), .idx(idx), .req(req), .valid_cnt(valid_cnt),
        .cnt_out(cnt_out), .busy(busy), .done(done), .error(error), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Environment / reference state
    logic [DATA_W-1:0] inq  [NCH][$];
    logic [DATA_W-1:0] outq [NCH][$];
    int   expq [NCH*NCH][$];
    int   exp_rx [NCH];
    int   pushed [NCH];
    int   out_peak [NCH];
    bit   in_af_seen;
    int   in_thr = 3;
    bit   force_empty = 1'b0;
    bit   fault_en = 1'b0, fault_done = 1'b0;
    int   run_n = 0;
    logic run_mode = 1'b0;

    function automatic logic [DATA_W-1:0] gen_word(input int src, input int k, input logic m);
        int d, s;
        d = m ? (k % NCH) : src;
        s = m ? (k / NCH) : k;
        return DATA_W'((d << (DATA_W - DEST_W)) + (src << SEQ_W) + s);
    endfunction

    // One clock of environment: consume pushes, serve pops, route, update flags
    task automatic tick();
        logic [DATA_W-1:0] w, shown;
        int wd, ws, wq, key;
        @(negedge clk);
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                inq[i].delete();
                outq[i].delete();
            end
            bus.almost_full_in = '0;
            bus.out_empty      = '1;
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            if (bus.push[i]) begin
                check_eq("push_af_gate", 32'(bus.almost_full_in[i]), 0);
                check_eq("push_in_range", 32'(pushed[i] < run_n), 1);
                check_eq("push_word", 32'(bus.data_in_flat[i*DATA_W +: DATA_W]),
                         32'(gen_word(i, pushed[i], run_mode)));
                check_eq("in_no_overflow", 32'(inq[i].size() < IN_DEPTH), 1);
                inq[i].push_back(bus.data_in_flat[i*DATA_W +: DATA_W]);
                pushed[i]++;
            end
        end
        for (int j = 0; j < NCH; j++) begin
            if (bus.pop[j]) begin
                check_eq("pop_not_empty", 32'(outq[j].size() != 0), 1);
                if (outq[j].size() != 0) begin
                    w = outq[j].pop_front();
                    shown = w;
                    if (fault_en && !fault_done && j == FAULT_J) begin
                        shown[DATA_W-DEST_W] = ~shown[DATA_W-DEST_W];
                        fault_done = 1'b1;
                    end
                    bus.data_out_flat[j*DATA_W +: DATA_W] = shown;
                    wd  = int'(w) >> (DATA_W - DEST_W);
                    ws  = (int'(w) >> SEQ_W) % NCH;
                    wq  = int'(w) % (1 << SEQ_W);
                    key = ws * NCH + j;
                    check_eq("route_dest", 32'(wd), 32'(j));
                    check_eq("word_expected", 32'(expq[key].size() != 0), 1);
                    if (expq[key].size() != 0) begin
                        check_eq("src_order", 32'(wq), 32'(expq[key].pop_front()));
                    end
                end
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (inq[i].size() != 0) begin
                w  = inq[i][0];
                wd = int'(w) >> (DATA_W - DEST_W);
                if (outq[wd].size() < OUT_DEPTH) begin
                    outq[wd].push_back(inq[i].pop_front());
                end
            end
        end
        for (int i = 0; i < NCH; i++) begin
            bus.almost_full_in[i] = (inq[i].size() >= in_thr);
            if (bus.almost_full_in[i]) in_af_seen = 1'b1;
            bus.out_empty[i] = force_empty || (outq[i].size() == 0);
            if (outq[i].size() > out_peak[i]) out_peak[i] = outq[i].size();
        end
    endtask

    task automatic prep_run(input logic m, input int n, input bit fault, input int thr);
        int d;
        run_mode = m; run_n = n; in_thr = thr;
        fault_en = fault; fault_done = 1'b0; in_af_seen = 1'b0;
        for (int i = 0; i < NCH*NCH; i++) expq[i].delete();
        for (int i = 0; i < NCH; i++) begin
            pushed[i] = 0; exp_rx[i] = 0; out_peak[i] = 0;
        end
        for (int i = 0; i < NCH; i++) begin
            for (int k = 0; k < n; k++) begin
                d = m ? (k % NCH) : i;
                expq[i*NCH + d].push_back(m ? (k / NCH) : k);
                exp_rx[d]++;
            end
        end
        mode = m;
        num_words = CNT_W'(n);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic read_cnt(input int j, input int exp);
        idx = DEST_W'(j);
        req = 1'b1;
        tick();
        check_eq($sformatf("cnt_valid[%0d]", j), 32'(valid_cnt), 1);
        check_eq($sformatf("cnt_out[%0d]", j), 32'(cnt_out), 32'(exp));
        req = 1'b0;
        tick();
        check_eq("cnt_valid_drop", 32'(valid_cnt), 0);
        check_eq("cnt_out_hold", 32'(cnt_out), 32'(exp));
    endtask

    task automatic run_test(input logic m, input int n, input int hold, input bit fault,
                            input int thr, input bit want_out_af, input bit want_in_af);
        int cyc;
        prep_run(m, n, fault, thr);
        hold_pop = (hold > 0);
        pulse_start();
        cyc = 0;
        while (!done && cyc < 4000) begin
            if (hold > 0 && cyc == hold) begin
                for (int j = 0; j < NCH; j++) begin
                    if (want_out_af) check_eq("out_af_seen", 32'(out_peak[j] >= OUT_AF), 1);
                end
                if (want_in_af) check_eq("in_af_seen", 32'(in_af_seen), 1);
                hold_pop = 1'b0;
            end
            tick();
            cyc++;
        end
        hold_pop = 1'b0;
        check_eq("run_done", 32'(done), 1);
        check_eq("run_busy_low", 32'(busy), 0);
        check_eq("run_error", 32'(error), 32'(fault));
        check_eq("run_err_count", 32'(err_count), 32'(fault));
        tick();
        tick();
        for (int i = 0; i < NCH; i++) begin
            check_eq("pushes_per_input", 32'(pushed[i]), 32'(n));
            check_eq("fifos_empty", 32'(inq[i].size() + outq[i].size()), 0);
        end
        for (int k = 0; k < NCH*NCH; k++) begin
            check_eq("all_words_rx", 32'(expq[k].size()), 0);
        end
        for (int j = 0; j < NCH; j++) read_cnt(j, exp_rx[j] % (1 << CNT_W));
        $display("run mode=%0d n=%0d hold=%0d fault=%0d thr=%0d: error=%0d err_count=%0d",
                 m, n, hold, fault, thr, error, err_count);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int cyc;
        bus.almost_full_in = '0;
        bus.out_empty      = '1;
        bus.data_out_flat  = '0;

        tick();
        tick();
        check_eq("rst_push", 32'(bus.push), 0);
        check_eq("rst_pop", 32'(bus.pop), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_error", 32'(error), 0);
        check_eq("rst_err_count", 32'(err_count), 0);
        check_eq("rst_valid_cnt", 32'(valid_cnt), 0);
        check_eq("rst_cnt_out", 32'(cnt_out), 0);
        reset = 1'b1;
        tick();

        // Straight, outputs filled while pops are held
        run_test(1'b0, 6, 30, 1'b0, 3, 1'b1, 1'b0);
        // Input back-pressure through almost_full_in
        run_test(1'b0, 20, 60, 1'b0, 3, 1'b0, 1'b1);
        // All-to-all, twice back to back from DONE
        run_test(1'b1, 4, 0, 1'b0, 3, 1'b0, 1'b0);
        run_test(1'b1, 4, 0, 1'b0, 3, 1'b0, 1'b0);
        // Zero words goes straight to DONE with cleared counters
        run_test(1'b0, 0, 0, 1'b0, 3, 1'b0, 1'b0);
        // One corrupted dest field
        run_test(1'b0, 6, 0, 1'b1, 3, 1'b0, 1'b0);
        // Randomised runs
        repeat (6) begin
            run_test(1'($urandom % 2), int'($urandom_range(1, 31)), int'($urandom_range(0, 40)),
                     1'b0, int'($urandom_range(1, 4)), 1'b0, 1'b0);
        end

        // Drain timeout: outputs appear empty forever
        prep_run(1'b0, 2, 1'b0, 3);
        hold_pop = 1'b1;
        pulse_start();
        repeat (20) tick();
        check_eq("to_busy", 32'(busy), 1);
        force_empty = 1'b1;
        bus.out_empty = '1;
        hold_pop = 1'b0;
        cyc = 0;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        check_eq("to_done", 32'(done), 1);
        check_eq("to_error", 32'(error), 1);
        check_eq("to_latency", 32'(cyc >= TIMEOUT - 2 && cyc <= TIMEOUT + 4), 1);
        $display("timeout run: done after %0d idle cycles, error=%0d", cyc, error);
        force_empty = 1'b0;
        do_reset();

        // Reset in the middle of SEND
        prep_run(1'b0, 20, 1'b0, 3);
        hold_pop = 1'b1;
        pulse_start();
        repeat (4) tick();
        check_eq("mid_busy", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_push", 32'(bus.push), 0);
        check_eq("mid_rst_pop", 32'(bus.pop), 0);
        check_eq("mid_rst_busy", 32'(busy), 0);
        check_eq("mid_rst_done", 32'(done), 0);
        tick();
        tick();
        reset = 1'b1;
        hold_pop = 1'b0;
        tick();
        run_test(1'b0, 5, 0, 1'b0, 3, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
